// File: rtl/ao_settle_checker.sv
// Settle/latency checker for two AND-OR implementations driven by the same {a,b,c} stimulus.
// Build option AO_CHECK_SYNC2_EN: two-stage synchronizer/delay on w1, w3 and in_vec (default one stage).
//
// state   | meaning
// IDLE    | waiting for a stimulus change
// MEASURE | tracking output changes until both are quiet or the timeout hits
// DONE    | one-cycle record strobe, mismatch count updated
module ao_settle_checker #(
    parameter int CNT_W      = 8,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       in_vec,
    input  logic             w1,
    input  logic             w3,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] lat1,
    output logic [CNT_W-1:0] lat3,
    output logic [CNT_W-1:0] lat_diff,
    output logic [1:0]       moved,
    output logic             agree,
    output logic             timed_out,
    output logic [7:0]       mismatch_cnt
);

`ifdef AO_CHECK_SYNC2_EN
    localparam int SYNC_N = 2;
`else
    localparam int SYNC_N = 1;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STABLE_V  = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_DONE} state_t;

    logic [SYNC_N-1:0]      w1_sync_q, w1_sync_d, w3_sync_q, w3_sync_d;
    logic [SYNC_N-1:0][2:0] in_dly_q, in_dly_d;
    logic                   w1_prev_q, w3_prev_q;
    logic [2:0]             in_prev_q;
    logic                   w1_s, w3_s, w1_chg, w3_chg, chg;
    logic [2:0]             in_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cyc_q, cyc_d, quiet_q, quiet_d;
    logic [CNT_W-1:0]       lat1_t_q, lat1_t_d, lat3_t_q, lat3_t_d;
    logic [1:0]             moved_t_q, moved_t_d;
    logic                   busy_q, busy_d, meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0]       lat1_q, lat1_d, lat3_q, lat3_d, lat_diff_q, lat_diff_d;
    logic [1:0]             moved_q, moved_d;
    logic                   agree_q, agree_d, timed_out_q, timed_out_d;
    logic [7:0]             cnt_q, cnt_d;

    logic [CNT_W-1:0]       lat1_n, lat3_n, quiet_n;
    logic [1:0]             moved_n;
    logic                   start, finish, fin_to;

    // Equal delay on stimulus and outputs keeps every latency input-referred.
    always_comb begin
        w1_sync_d    = w1_sync_q;
        w3_sync_d    = w3_sync_q;
        in_dly_d     = in_dly_q;
        w1_sync_d[0] = w1;
        w3_sync_d[0] = w3;
        in_dly_d[0]  = in_vec;
        for (int i = 1; i < SYNC_N; i++) begin
            w1_sync_d[i] = w1_sync_q[i-1];
            w3_sync_d[i] = w3_sync_q[i-1];
            in_dly_d[i]  = in_dly_q[i-1];
        end
    end

    assign w1_s   = w1_sync_q[SYNC_N-1];
    assign w3_s   = w3_sync_q[SYNC_N-1];
    assign in_d   = in_dly_q[SYNC_N-1];
    assign chg    = (in_d != in_prev_q);
    assign w1_chg = (w1_s != w1_prev_q);
    assign w3_chg = (w3_s != w3_prev_q);

    // cyc_q holds the index of the current MEASURE cycle; the detecting chg cycle is 0.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        quiet_d      = quiet_q;
        lat1_t_d     = lat1_t_q;
        lat3_t_d     = lat3_t_q;
        moved_t_d    = moved_t_q;
        lat1_d       = lat1_q;
        lat3_d       = lat3_q;
        lat_diff_d   = lat_diff_q;
        moved_d      = moved_q;
        agree_d      = agree_q;
        timed_out_d  = timed_out_q;
        cnt_d        = cnt_q;
        meas_valid_d = 1'b0;
        start        = 1'b0;
        finish       = 1'b0;
        fin_to       = 1'b0;

        lat1_n  = w1_chg ? cyc_q : lat1_t_q;
        lat3_n  = w3_chg ? cyc_q : lat3_t_q;
        moved_n = moved_t_q | {w1_chg, w3_chg};
        quiet_n = (w1_chg || w3_chg) ? '0 : quiet_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: start = chg;
            ST_MEASURE: begin
                if (chg) begin
                    start = 1'b1;
                end else begin
                    cyc_d     = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_W'(1);
                    quiet_d   = quiet_n;
                    lat1_t_d  = lat1_n;
                    lat3_t_d  = lat3_n;
                    moved_t_d = moved_n;
                    if (quiet_n == STABLE_V) begin
                        finish = 1'b1;
                    end else if (cyc_q == TIMEOUT_V) begin
                        finish = 1'b1;
                        fin_to = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                start   = chg;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d   = ST_MEASURE;
            cyc_d     = CNT_W'(1);
            quiet_d   = '0;
            lat1_t_d  = '0;
            lat3_t_d  = '0;
            moved_t_d = {w1_chg, w3_chg};
        end

        if (finish) begin
            state_d      = ST_DONE;
            meas_valid_d = 1'b1;
            lat1_d       = lat1_n;
            lat3_d       = lat3_n;
            lat_diff_d   = (lat1_n >= lat3_n) ? lat1_n - lat3_n : lat3_n - lat1_n;
            moved_d      = moved_n;
            agree_d      = (w1_s == w3_s);
            timed_out_d  = fin_to;
            if (((w1_s != w3_s) || fin_to) && (cnt_q != 8'hFF))
                cnt_d = cnt_q + 8'd1;
        end

        busy_d = (state_d == ST_MEASURE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1_sync_q    <= '0;
            w3_sync_q    <= '0;
            in_dly_q     <= '0;
            w1_prev_q    <= 1'b0;
            w3_prev_q    <= 1'b0;
            in_prev_q    <= '0;
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            quiet_q      <= '0;
            lat1_t_q     <= '0;
            lat3_t_q     <= '0;
            moved_t_q    <= '0;
            busy_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            lat1_q       <= '0;
            lat3_q       <= '0;
            lat_diff_q   <= '0;
            moved_q      <= '0;
            agree_q      <= 1'b0;
            timed_out_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            w1_sync_q    <= w1_sync_d;
            w3_sync_q    <= w3_sync_d;
            in_dly_q     <= in_dly_d;
            w1_prev_q    <= w1_s;
            w3_prev_q    <= w3_s;
            in_prev_q    <= in_d;
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            quiet_q      <= quiet_d;
            lat1_t_q     <= lat1_t_d;
            lat3_t_q     <= lat3_t_d;
            moved_t_q    <= moved_t_d;
            busy_q       <= busy_d;
            meas_valid_q <= meas_valid_d;
            lat1_q       <= lat1_d;
            lat3_q       <= lat3_d;
            lat_diff_q   <= lat_diff_d;
            moved_q      <= moved_d;
            agree_q      <= agree_d;
            timed_out_q  <= timed_out_d;
            cnt_q        <= cnt_d;
        end
    end

    assign busy         = busy_q;
    assign meas_valid   = meas_valid_q;
    assign lat1         = lat1_q;
    assign lat3         = lat3_q;
    assign lat_diff     = lat_diff_q;
    assign moved        = moved_q;
    assign agree        = agree_q;
    assign timed_out    = timed_out_q;
    assign mismatch_cnt = cnt_q;

endmodule
